// File: rtl/step_watchdog_pkg.sv
// rtl/step_watchdog_pkg.sv - shared constants and FSM encodings for the step watchdog
package step_watchdog_pkg;

  // Width of every per-channel idle counter
  localparam int CNT_W = 32;

  // Watchdog supervisor states
  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_TRIPPED  = 2'd2
  } wd_state_t;

endpackage

// File: rtl/step_idle_chan.sv
// rtl/step_idle_chan.sv - one step channel: edge detect, idle counter, idle alert, rate violation flag
module step_idle_chan
  import step_watchdog_pkg::*;
#(
  parameter logic [CNT_W-1:0] IDLE_LIMIT   = 32'd480000000,
  parameter logic [CNT_W-1:0] MIN_INTERVAL = 32'd48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_step,
  input  logic       i_clr,
  output logic       o_alert,
  output logic       o_too_fast,
  output logic [7:0] o_cnt_hi
);

  logic             r_step;
  logic             r_primed;
  logic             r_seen;
  logic             r_alert;
  logic             r_too_fast;
  logic [CNT_W-1:0] r_cnt;
  logic             w_edge;

  // r_primed masks the first post-reset cycle so the initial capture of step is not an edge
  assign w_edge = r_primed & (i_step ^ r_step);

  // Edge detect, saturating idle counter, idle alert and sticky rate flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step     <= 1'b0;
      r_primed   <= 1'b0;
      r_seen     <= 1'b0;
      r_alert    <= 1'b0;
      r_too_fast <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_step   <= i_step;
      r_primed <= 1'b1;

      // An edge beats saturation: the counter restarts even when parked at the limit
      if (w_edge) begin
        r_cnt <= '0;
      end else if (r_cnt != IDLE_LIMIT) begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_alert <= ~w_edge & (r_cnt == IDLE_LIMIT);

      // clr wins over a coincident edge; the next edge is then treated as the first one
      if (i_clr) begin
        r_seen     <= 1'b0;
        r_too_fast <= 1'b0;
      end else if (w_edge) begin
        r_seen <= 1'b1;
        if (r_seen && (r_cnt < MIN_INTERVAL)) begin
          r_too_fast <= 1'b1;
        end
      end
    end
  end

  assign o_alert    = r_alert;
  assign o_too_fast = r_too_fast;
  assign o_cnt_hi   = r_cnt[CNT_W-1:CNT_W-8];

endmodule

// File: rtl/step_watchdog.sv
// rtl/step_watchdog.sv - stepper output watchdog: per-channel idle/rate monitors plus arm/trip supervisor
module step_watchdog
  import step_watchdog_pkg::*;
#(
  parameter int HZ           = 48000000,
  parameter int NSTEPDIR     = 6,
  parameter int IDLE_SEC     = 10,
  parameter int MIN_INTERVAL = 48,
  parameter int WATCH_CH     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NSTEPDIR-1:0] step,
  input  logic                arm_n,
  input  logic                clr,
  output logic [NSTEPDIR-1:0] alert,
  output logic [NSTEPDIR-1:0] too_fast,
  output logic                armed,
  output logic                req_shutdown,
  output logic [7:0]          idle_dbg
);

  localparam logic [CNT_W-1:0] LP_IDLE_LIMIT = CNT_W'(HZ * IDLE_SEC);
  localparam logic [CNT_W-1:0] LP_MIN_INT    = CNT_W'(MIN_INTERVAL);

  logic [7:0] w_cnt_hi [NSTEPDIR];
  logic [7:0] w_dbg;
  logic       w_trip;
  logic       r_arm_meta;
  logic       r_arm_sync;
  logic       r_armed;
  logic       r_req_shutdown;
  logic [7:0] r_idle_dbg;
  wd_state_t  r_state;

  genvar g;
  generate
    for (g = 0; g < NSTEPDIR; g++) begin : g_chan
      step_idle_chan #(
        .IDLE_LIMIT   (LP_IDLE_LIMIT),
        .MIN_INTERVAL (LP_MIN_INT)
      ) u_chan (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_step     (step[g]),
        .i_clr      (clr),
        .o_alert    (alert[g]),
        .o_too_fast (too_fast[g]),
        .o_cnt_hi   (w_cnt_hi[g])
      );
    end
  endgenerate

  // Pick the watched channel's counter top byte for the debug port
  always_comb begin
    w_dbg = '0;
    for (int i = 0; i < NSTEPDIR; i++) begin
      if (i == WATCH_CH) begin
        w_dbg = w_cnt_hi[i];
      end
    end
  end

  assign w_trip = alert[WATCH_CH] | (|too_fast);

  // Two-flop synchroniser on the inverted endstop, so the cleared state means "not arming"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm_meta <= 1'b0;
      r_arm_sync <= 1'b0;
    end else begin
      r_arm_meta <= ~arm_n;
      r_arm_sync <= r_arm_meta;
    end
  end

  // Supervisor FSM with outputs registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_DISARMED;
      r_armed        <= 1'b0;
      r_req_shutdown <= 1'b0;
    end else begin
      case (r_state)
        ST_DISARMED: begin
          if (r_arm_sync) begin
            r_state <= ST_ARMED;
            r_armed <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (w_trip) begin
            r_state        <= ST_TRIPPED;
            r_req_shutdown <= 1'b1;
          end
        end
        ST_TRIPPED: begin
          // A still-present trip condition overrides clr
          if (clr && !w_trip) begin
            r_state        <= ST_DISARMED;
            r_armed        <= 1'b0;
            r_req_shutdown <= 1'b0;
          end
        end
        default: begin
          r_state        <= ST_DISARMED;
          r_armed        <= 1'b0;
          r_req_shutdown <= 1'b0;
        end
      endcase
    end
  end

  // Debug snapshot of the watched idle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_dbg <= '0;
    end else begin
      r_idle_dbg <= w_dbg;
    end
  end

  assign armed        = r_armed;
  assign req_shutdown = r_req_shutdown;
  assign idle_dbg     = r_idle_dbg;

endmodule

// File: tb/tb_step_watchdog.sv
// tb/tb_step_watchdog.sv - directed self-checking bench for step_watchdog
module tb_step_watchdog;

  logic       clk;
  logic       rst_n;
  logic [5:0] step;
  logic       arm_n;
  logic       clr;
  logic [5:0] alert;
  logic [5:0] too_fast;
  logic       armed;
  logic       req_shutdown;
  logic [7:0] idle_dbg;

  int n_pass;
  int n_total;

  step_watchdog #(
    .HZ           (100),
    .NSTEPDIR     (6),
    .IDLE_SEC     (1),
    .MIN_INTERVAL (4),
    .WATCH_CH     (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .step         (step),
    .arm_n        (arm_n),
    .clr          (clr),
    .alert        (alert),
    .too_fast     (too_fast),
    .armed        (armed),
    .req_shutdown (req_shutdown),
    .idle_dbg     (idle_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    step    = 6'h00;
    arm_n   = 1'b1;
    clr     = 1'b0;

    // Reset state
    tick(3);
    chk("rst_alert", 32'(alert), 32'h0);
    chk("rst_too_fast", 32'(too_fast), 32'h0);
    chk("rst_armed", 32'(armed), 32'h0);
    chk("rst_req", 32'(req_shutdown), 32'h0);
    chk("rst_dbg", 32'(idle_dbg), 32'h0);

    // Idle timeout: counters reach 100 at edge 100, alert registers at edge 101
    rst_n = 1'b1;
    tick(100);
    chk("idle_alert_100", 32'(alert), 32'h0);
    tick(1);
    chk("idle_alert_101", 32'(alert), 32'h3F);
    chk("idle_no_shutdown", 32'(req_shutdown), 32'h0);
    chk("idle_not_armed", 32'(armed), 32'h0);
    chk("idle_dbg_small", 32'(idle_dbg), 32'h0);

    // Edge on a saturated counter: restart wins, alert drops next cycle
    step[0] = 1'b1;
    tick(1);
    chk("sat_edge_alert", 32'(alert), 32'h3E);
    chk("sat_edge_no_flag", 32'(too_fast), 32'h0);

    // Fresh reset, then arm through the synchroniser
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    arm_n = 1'b0;
    tick(2);
    chk("arm_sync_delay", 32'(armed), 32'h0);
    tick(1);
    chk("arm_set", 32'(armed), 32'h1);
    arm_n = 1'b1;
    tick(47);
    chk("arm_persists", 32'(armed), 32'h1);
    chk("arm_no_req", 32'(req_shutdown), 32'h0);
    tick(50);
    chk("watch_alert_100", 32'(alert), 32'h0);
    tick(1);
    chk("watch_alert_101", 32'(alert), 32'h3F);
    chk("watch_req_pending", 32'(req_shutdown), 32'h0);
    tick(1);
    chk("watch_trip_req", 32'(req_shutdown), 32'h1);
    chk("watch_trip_armed", 32'(armed), 32'h1);

    // clr while alert[5] still high keeps TRIPPED
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_race_req", 32'(req_shutdown), 32'h1);
    chk("clr_race_armed", 32'(armed), 32'h1);
    step[5] = 1'b1;
    tick(1);
    chk("watch_alert_drop", 32'(alert[5]), 32'h0);
    chk("watch_step_no_flag", 32'(too_fast), 32'h0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_disarm_armed", 32'(armed), 32'h0);
    chk("clr_disarm_req", 32'(req_shutdown), 32'h0);

    // Re-arm and exercise the step-rate check on channel 2
    arm_n = 1'b0;
    tick(3);
    arm_n = 1'b1;
    chk("rearm", 32'(armed), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step[2] = ~step[2];
      tick(10);
    end
    chk("slow_rate_flag", 32'(too_fast), 32'h0);
    chk("slow_rate_req", 32'(req_shutdown), 32'h0);
    step[2] = ~step[2];
    tick(2);
    step[2] = ~step[2];
    tick(1);
    chk("fast_rate_flag", 32'(too_fast), 32'h04);
    chk("fast_rate_req_pending", 32'(req_shutdown), 32'h0);
    tick(1);
    chk("fast_rate_trip", 32'(req_shutdown), 32'h1);

    // clr clears the flag but the registered flag still holds TRIPPED this cycle
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_vs_flag_req", 32'(req_shutdown), 32'h1);
    chk("clr_vs_flag_cleared", 32'(too_fast), 32'h0);

    // Asynchronous reset while TRIPPED with several alerts up
    rst_n = 1'b0;
    #1;
    chk("arst_alert", 32'(alert), 32'h0);
    chk("arst_too_fast", 32'(too_fast), 32'h0);
    chk("arst_armed", 32'(armed), 32'h0);
    chk("arst_req", 32'(req_shutdown), 32'h0);
    chk("arst_dbg", 32'(idle_dbg), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    step[2] = ~step[2];
    tick(1);
    chk("post_rst_first_edge", 32'(too_fast), 32'h0);
    step[2] = ~step[2];
    tick(1);
    chk("post_rst_second_edge", 32'(too_fast), 32'h04);
    tick(1);
    chk("disarmed_no_trip", 32'(req_shutdown), 32'h0);
    chk("disarmed_armed", 32'(armed), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/step_watchdog.md
STEP_WATCHDOG -- requirements
Module: step_watchdog

Interface
REQ-001 SHALL have parameter HZ, default 48000000, system clock frequency in Hz.
REQ-002 SHALL have parameter NSTEPDIR, default 6, number of step channels monitored.
REQ-003 SHALL have parameter IDLE_SEC, default 10, idle timeout in seconds; IDLE_LIMIT = HZ*IDLE_SEC cycles.
REQ-004 SHALL have parameter MIN_INTERVAL, default 48, minimum legal cycles between step edges.
REQ-005 SHALL have parameter WATCH_CH, default 5, channel whose idle timeout trips shutdown.
REQ-006 SHALL have port clk, input, 1, system clock; one clock domain only.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port step, input, NSTEPDIR, step outputs from the stepper core, synchronous to clk.
REQ-009 SHALL have port arm_n, input, 1, asynchronous endstop pin; low arms the watchdog.
REQ-010 SHALL have port clr, input, 1, single-cycle pulse clearing the trip and sticky flags.
REQ-011 SHALL have port alert, output, NSTEPDIR, per-channel idle-limit-reached level.
REQ-012 SHALL have port too_fast, output, NSTEPDIR, per-channel sticky step-rate violation.
REQ-013 SHALL have port armed, output, 1, high in ARMED or TRIPPED.
REQ-014 SHALL have port req_shutdown, output, 1, high only in TRIPPED.
REQ-015 SHALL have port idle_dbg, output, 8, bits [31:24] of the WATCH_CH idle counter.

Function
REQ-016 SHALL register step each cycle; a step edge on channel i is step[i] differing from its registered value (both edges count).
REQ-017 SHALL keep a 32-bit idle counter per channel: 0 on an edge, else +1, saturating at IDLE_LIMIT.
REQ-018 SHALL give an edge priority over saturation in the same cycle (counter becomes 0).
REQ-019 SHALL drive alert[i] registered, high the cycle after counter i equals IDLE_LIMIT, low the cycle after an edge.
REQ-020 SHALL set too_fast[i] when an edge occurs with counter i < MIN_INTERVAL; sticky until clr or reset.
REQ-021 SHALL not flag the first edge after reset or clr as too_fast (per-channel seen flag, cleared by clr).
REQ-022 SHALL synchronise arm_n through two flops before use.
REQ-023 SHALL implement FSM DISARMED -> ARMED on synced arm_n low; ARMED -> TRIPPED when alert[WATCH_CH] or any too_fast is high; TRIPPED -> DISARMED on clr.
REQ-024 SHALL keep TRIPPED if clr coincides with a trip condition (safety wins); clr in other states only clears flags.
REQ-025 SHALL ignore arm_n returning high; ARMED persists until trip or reset.
REQ-026 SHALL assert req_shutdown registered, one cycle after the trip condition is seen.

Reset
REQ-027 SHALL on rst_n low clear counters, registered step, sync flops, seen flags, alert, too_fast, armed, req_shutdown, idle_dbg and enter DISARMED asynchronously.
REQ-028 SHALL capture the step input as the new registered value on the first post-reset cycle, without generating an edge.

Structure
REQ-029 SHALL place FSM state encodings and the 32-bit counter width constant in the shared project package.
REQ-030 SHALL use one sub-module, step_idle_chan (edge detect, counter, alert, too_fast), instantiated NSTEPDIR times; top holds sync and FSM.

Verification (HZ=100, IDLE_SEC=1, MIN_INTERVAL=4, NSTEPDIR=6, WATCH_CH=5)
REQ-031 SHALL test idle: no steps for 100 cycles after reset -> alert=6'h3F at cycle 101, req_shutdown stays 0 (not armed).
REQ-032 SHALL test arm and trip: arm_n low 3 cycles, step5 held -> armed=1 after 2-3 cycles, req_shutdown=1 one cycle after alert[5].
REQ-033 SHALL test rate: toggle step2 every 2 cycles while ARMED -> too_fast[2]=1 on second edge, TRIPPED; toggle every 10 cycles -> no flag.
REQ-034 SHALL test clr race: clr pulsed in the same cycle alert[5] is high -> state stays TRIPPED; clr later -> DISARMED, armed=0.
REQ-035 SHALL test edge-vs-saturation: step edge at counter=IDLE_LIMIT -> counter 0, alert drops next cycle.
REQ-036 SHALL test reset mid-TRIPPED: rst_n low -> all outputs 0 immediately, no too_fast on first subsequent edge.
